digit_module_chain: RTL and testbench

Higher-order digit of the clock/timer digit chain: the receiving end of the carry protocol that the least-significant digit drives. It detects the carry request addressed to it on the shared `toDigit`/`fromDigit` one-hot bus, increments (or optionally decrements) its own digit modulo `maximumBits+1`, and issues a carry to the next digit on wrap. Instances are cascaded HSB→LMB→HMB→LHB→HHB, and each one is distinguished only by `IDENTITY`.

---
 rtl/digit_module_chain.sv | 111 +++++++++++
 tb/tb_digit_module_chain.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/digit_module_chain.sv
// Higher-order digit of the clock/timer chain: counts carry events addressed to it on the one-hot bus and carries out on wrap.
// Optional feature: define DIGIT_DOWN_EN to add the countDown port (decrement with borrow on underflow).
module digit_module_chain #(
   parameter int IDENTITY = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] state,
   input  logic [5:0] toDigit,
   input  logic       otherBitsMove,
   input  logic [3:0] setBits,
   input  logic [3:0] maximumBits,
`ifdef DIGIT_DOWN_EN
   input  logic       countDown,
`endif
   output logic [3:0] outputBits,
   output logic [5:0] fromDigit,
   output logic       otherBitsMoveOut
);

   // state | meaning
   // RESET | digit, edge detector and carry cleared
   // SET   | digit preloaded with min(setBits, maximumBits)
   // START | digit advances on each qualified rising edge of its request bit
   typedef enum logic [1:0] {
      RESET = 2'd0,
      SET   = 2'd1,
      START = 2'd2
   } fsm_t;

   localparam logic [6:0] CARRY_WIDE = 7'd1 << IDENTITY;
   localparam logic [5:0] CARRY_MASK = CARRY_WIDE[5:0];

   fsm_t       fsm;
   fsm_t       nextFsm;
   logic [3:0] count;
   logic       prev;
   logic       reqBit;
   logic       digitEvent;
   logic       goDown;

   assign reqBit     = toDigit[IDENTITY-1];
   assign digitEvent = reqBit && !prev && otherBitsMove;
   assign outputBits = count;

`ifdef DIGIT_DOWN_EN
   assign goDown = countDown;
`else
   assign goDown = 1'b0;
`endif

   // Command decode; START may not fall back to SET, so that command holds START.
   always_comb begin
      nextFsm = fsm;
      case (state)
         4'd0:    nextFsm = RESET;
         4'd1:    nextFsm = (fsm == START) ? START : SET;
         4'd3:    nextFsm = START;
         default: nextFsm = fsm;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm              <= RESET;
         count            <= 4'd0;
         prev             <= 1'b0;
         fromDigit        <= 6'd0;
         otherBitsMoveOut <= 1'b0;
      end else begin
         fsm              <= nextFsm;
         fromDigit        <= 6'd0;
         otherBitsMoveOut <= 1'b0;
         case (nextFsm)
            RESET: begin
               count <= 4'd0;
               prev  <= 1'b0;
            end
            SET: begin
               count <= (setBits > maximumBits) ? maximumBits : setBits;
               prev  <= reqBit;
            end
            START: begin
               prev <= reqBit;
               if (digitEvent) begin
                  if (goDown) begin
                     if (count == 4'd0) begin
                        count            <= maximumBits;
                        fromDigit        <= CARRY_MASK;
                        otherBitsMoveOut <= 1'b1;
                     end else begin
                        count <= count - 4'd1;
                     end
                  end else if (count >= maximumBits) begin
                     count            <= 4'd0;
                     fromDigit        <= CARRY_MASK;
                     otherBitsMoveOut <= 1'b1;
                  end else begin
                     count <= count + 4'd1;
                  end
               end
            end
            default: begin
               count <= 4'd0;
               prev  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_digit_module_chain.sv
// Directed self-checking bench for digit_module_chain (IDENTITY=2, HSB position).
// Build with DIGIT_DOWN_EN defined to also exercise the countdown path.
module tb_digit_module_chain;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] state;
   logic [5:0] toDigit;
   logic       otherBitsMove;
   logic [3:0] setBits;
   logic [3:0] maximumBits;
   logic       countDown;
   logic [3:0] outputBits;
   logic [5:0] fromDigit;
   logic       otherBitsMoveOut;

   int errCnt = 0;
   int chkCnt = 0;
   int carryCnt;

   localparam logic [5:0] REQ   = 6'b000010;
   localparam logic [5:0] CARRY = 6'b000100;

   digit_module_chain #(.IDENTITY(2)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .state            (state),
      .toDigit          (toDigit),
      .otherBitsMove    (otherBitsMove),
      .setBits          (setBits),
      .maximumBits      (maximumBits),
`ifdef DIGIT_DOWN_EN
      .countDown        (countDown),
`endif
      .outputBits       (outputBits),
      .fromDigit        (fromDigit),
      .otherBitsMoveOut (otherBitsMoveOut)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      chkCnt++;
      if (obs !== exp) begin
         errCnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle to the falling edge for sampling and driving.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_carry(input string tag, input logic [3:0] cnt, input logic on);
      check_val({tag, ".count"}, 16'(outputBits), 16'(cnt));
      check_val({tag, ".from"}, 16'(fromDigit), on ? 16'(CARRY) : 16'd0);
      check_val({tag, ".omo"}, 16'(otherBitsMoveOut), 16'(on));
   endtask

   initial begin
      rst_n = 1'b0; state = 4'd0; toDigit = 6'd0; otherBitsMove = 1'b0;
      setBits = 4'd0; maximumBits = 4'd5; countDown = 1'b0;
      #1;
      check_carry("reset", 4'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // async reset mid-count
      state = 4'd1; setBits = 4'd3;
      step();
      check_val("preset3", 16'(outputBits), 16'd3);
      state = 4'd3;
      step();
      #2 rst_n = 1'b0;
      #1 check_carry("asyncRst", 4'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // SET clamps to maximum
      state = 4'd1; setBits = 4'd7; maximumBits = 4'd5;
      step();
      check_val("setClamp", 16'(outputBits), 16'd5);
      setBits = 4'd4;
      step();
      state = 4'd3;
      step();
      check_val("startHold", 16'(outputBits), 16'd4);

      // long-held request gives one event
      toDigit = REQ; otherBitsMove = 1'b1;
      step();
      check_carry("firstEdge", 4'd5, 1'b0);
      carryCnt = 0;
      for (int i = 0; i < 19; i++) begin
         step();
         if (fromDigit != 6'd0) carryCnt++;
      end
      check_val("heldCount", 16'(outputBits), 16'd5);
      check_val("heldCarries", 16'(carryCnt), 16'd0);

      // wrap with one-cycle carry
      toDigit = 6'd0;
      step();
      toDigit = REQ;
      step();
      check_carry("wrap", 4'd0, 1'b1);
      step();
      check_carry("wrapFall", 4'd0, 1'b0);

      // qualification: edge with otherBitsMove low is consumed
      toDigit = 6'd0;
      step();
      otherBitsMove = 1'b0; toDigit = REQ;
      step();
      check_val("unqualEdge", 16'(outputBits), 16'd0);
      otherBitsMove = 1'b1;
      step();
      check_val("lateQual", 16'(outputBits), 16'd0);
      toDigit = 6'd0;
      step();
      toDigit = REQ;
      step();
      check_val("qualEdge", 16'(outputBits), 16'd1);

      // SET command while counting is ignored
      state = 4'd1; setBits = 4'd3;
      step();
      check_val("illegalSet", 16'(outputBits), 16'd1);
      toDigit = 6'd0;
      step();
      toDigit = REQ;
      step();
      check_val("afterIllegal", 16'(outputBits), 16'd2);
      state = 4'd3;

      // maximum lowered below count, then zero maximum
      maximumBits = 4'd0;
      toDigit = 6'd0;
      step();
      toDigit = REQ;
      step();
      check_carry("lowerMax", 4'd0, 1'b1);
      carryCnt = 0;
      for (int i = 0; i < 3; i++) begin
         toDigit = 6'd0;
         step();
         if (fromDigit != 6'd0) carryCnt++;
         toDigit = REQ;
         step();
         if (fromDigit == CARRY && otherBitsMoveOut && outputBits == 4'd0) carryCnt++;
      end
      check_val("zeroMaxCarries", 16'(carryCnt), 16'd3);
      step();
      check_carry("zeroMaxEnd", 4'd0, 1'b0);

      // RESET command drops a pending carry
      maximumBits = 4'd5;
      toDigit = 6'd0;
      step();
      toDigit = REQ;
      step();
      check_val("preRst", 16'(outputBits), 16'd1);
      toDigit = 6'd0;
      step();
      toDigit = REQ; maximumBits = 4'd1;
      step();
      check_carry("wrapBeforeCmd", 4'd0, 1'b1);
      maximumBits = 4'd5;
      toDigit = 6'd0;
      step();
      toDigit = REQ;
      step();
      check_val("preRst2", 16'(outputBits), 16'd1);
      toDigit = 6'd0;
      step();
      toDigit = REQ; maximumBits = 4'd1; state = 4'd0;
      step();
      check_carry("cmdRst", 4'd0, 1'b0);

`ifdef DIGIT_DOWN_EN
      state = 4'd1; setBits = 4'd0; maximumBits = 4'd9; toDigit = 6'd0;
      step();
      state = 4'd3; countDown = 1'b1;
      step();
      toDigit = REQ;
      step();
      check_carry("borrow", 4'd9, 1'b1);
      toDigit = 6'd0;
      step();
      toDigit = REQ;
      step();
      check_carry("down", 4'd8, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

endmodule
